multiplier_array_seq_reconstruct_8: RTL and testbench
=====================================================

Name: multiplier_array_seq_reconstruct_8

Overview:
Sequential shift-add multiplier that inverts the 16/8 array divider: it rebuilds the dividend from a quotient/divisor/remainder triple, n = q*d + r.
Used as the reconstruction stage in the divider evaluation path, where the recovered n is compared against the original dividend to quantify error from the approximate divider cells.
One W-bit multiplier bit is retired per cycle, with valid/ready handshakes on both the input and the output side.

Parameters:
W, 8, operand width of q, d and r; the result is 2*W bits.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  q/d/r operands are valid.
in_ready  output  1  block can accept operands; high only in IDLE.
q  input  W  quotient (multiplier).
d  input  W  divisor (multiplicand).
r  input  W  remainder (addend).
out_valid  output  1  n is valid; held until accepted.
out_ready  input  1  consumer accepts n.
n  output  2*W  reconstructed dividend q*d + r.
busy  output  1  high in MUL and DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, busy = 0, n = 0, accumulator = 0, counter = 0.
- Reset asserted mid-operation aborts immediately. The in-flight result is discarded and never presented.
- States:
  - IDLE: wait for operands.
  - MUL: one shift-add step per cycle.
  - DONE: present the result.
- IDLE -> MUL on an edge with in_valid && in_ready. On that edge:
  - acc = zero-extended r;
  - mcand = zero-extended d (2*W bits);
  - mplier = q;
  - cnt = 0.
- MUL, each edge:
  - if mplier[0], acc = acc + mcand (2*W-bit add, no overflow possible since max 255*255+255 = 0xFF00 for W = 8);
  - mcand shifts left 1; mplier shifts right 1; cnt increments.
  - When cnt reaches W-1 on that edge, go to DONE and load n with the final acc.
- Latency: out_valid rises exactly W cycles after the accepting edge (8 cycles for W = 8).
- DONE: out_valid = 1 and n is held stable while out_ready is low.
  - On an edge with out_valid && out_ready, go to IDLE and clear out_valid. n keeps its last value.
- No same-cycle re-accept: in_ready rises in the cycle after the result handshake. Maximum throughput is one result per W+2 cycles.
- in_valid while not in IDLE is ignored. Operands are sampled only on the accepting edge; q/d/r may change afterwards.
- d = 0 or q = 0 gives n = r, with the same latency.

Optional Feature:
Macro: MULT_EARLY_EXIT_EN.
- Defined: in MUL, when the shifted mplier (after the current step) is zero, go to DONE on that edge.
  - Latency becomes max(1, index of the MSB set in q + 1) cycles; q = 0 gives 1 cycle.
  - The result value is unchanged.
- Undefined: fixed W-cycle latency as above. The bench selects its expected latency by the same macro.

Decomposition:
- Shared package multiplier_reconstruct_pkg holds:
  - localparam W_DEF = 8;
  - state enum {IDLE, MUL, DONE} (2-bit);
  - counter width function clog2(W).
- One natural sub-module, shift_add_step: purely combinational; takes acc, mcand, mplier_lsb and returns next acc. It is reused by a future pipelined variant.
- The FSM, counter and handshakes stay in the top module.

Test Plan:
- q = 0x0C, d = 0x0F, r = 0x03 with out_ready = 1 -> n = 0x00B7, out_valid exactly 8 cycles after acceptance, one-cycle pulse.
- q = 0xFF, d = 0xFF, r = 0xFF -> n = 0xFF00. in_ready is low for the whole operation; busy is high throughout.
- q = 0x00, d = 0xAB, r = 0x5A -> n = 0x005A. Latency is 8 cycles, or 1 cycle with MULT_EARLY_EXIT_EN.
- q = 0x03, d = 0x10, r = 0, with out_ready held low 5 cycles after out_valid -> n = 0x0030 stable and out_valid high until out_ready; in_ready is high the cycle after the handshake.
- Start q = 0x7F, d = 0x7F, drop rst_n at cycle 4 of MUL -> outputs return to reset values asynchronously and no out_valid appears. The next transaction, q = 0x02, d = 0x05, r = 0x01, gives n = 0x000B.
- Back-to-back in_valid held high across 3 transactions with random operands -> each n = q*d + r, exactly 3 accepts, no operand sampled outside IDLE.

Source files
------------

// File: rtl/multiplier_reconstruct_pkg.sv
// Shared definitions for the q*d + r reconstruction multiplier family.
// Optional feature macro used by the top level: MULT_EARLY_EXIT_EN.
package multiplier_reconstruct_pkg;

  localparam int unsigned W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of bits needed to index `value` distinct positions
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned p = 1; p < value; p = p << 1) begin
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/multiplier_array_seq_reconstruct_8_shift_add_step.sv
// One shift-add multiplication step: conditionally adds the multiplicand
// into the accumulator. Purely combinational so it can be dropped into a
// pipelined variant unchanged.
module shift_add_step #(
  parameter int unsigned W = 8
) (
  input  logic [2*W-1:0] i_acc,
  input  logic [2*W-1:0] i_mcand,
  input  logic           i_mplier_lsb,
  output logic [2*W-1:0] o_acc_next
);

  // Add the multiplicand only when the current multiplier bit is set
  always_comb begin
    o_acc_next = i_acc;
    if (i_mplier_lsb) begin
      o_acc_next = i_acc + i_mcand;
    end
  end

endmodule

// File: rtl/multiplier_array_seq_reconstruct_8.sv
// Sequential shift-add multiplier rebuilding n = q*d + r from a divider's
// quotient/divisor/remainder. One multiplier bit retired per cycle with
// valid/ready handshakes on both sides.
// Optional macro MULT_EARLY_EXIT_EN: finish as soon as the remaining
// multiplier bits are all zero.
module multiplier_array_seq_reconstruct_8
  import multiplier_reconstruct_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   q,
  input  logic [W-1:0]   d,
  input  logic [W-1:0]   r,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] n,
  output logic           busy
);

  localparam int unsigned     CNT_W    = (clog2(W) > 0) ? clog2(W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  state_t           r_state;
  logic [2*W-1:0]   r_acc;
  logic [2*W-1:0]   r_mcand;
  logic [W-1:0]     r_mplier;
  logic [CNT_W-1:0] r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic [2*W-1:0]   r_n;

  logic [2*W-1:0]   w_acc_next;
  logic             w_last;

  shift_add_step #(
    .W (W)
  ) u_step (
    .i_acc        (r_acc),
    .i_mcand      (r_mcand),
    .i_mplier_lsb (r_mplier[0]),
    .o_acc_next   (w_acc_next)
  );

`ifdef MULT_EARLY_EXIT_EN
  logic [W-1:0] w_mplier_shr;

  // Last step when the counter expires or no multiplier bits remain
  always_comb begin
    w_mplier_shr = r_mplier >> 1;
    w_last       = (r_cnt == CNT_LAST) || (w_mplier_shr == '0);
  end
`else
  // Last step after exactly W multiplier bits
  always_comb begin
    w_last = (r_cnt == CNT_LAST);
  end
`endif

  // Control FSM, datapath registers and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_n         <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_acc      <= {{W{1'b0}}, r};
            r_mcand    <= {{W{1'b0}}, d};
            r_mplier   <= q;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= MUL;
          end
        end
        MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_n         <= w_acc_next;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          // in_ready returns only after this edge, so no same-cycle re-accept
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign n         = r_n;
  assign busy      = r_busy;

endmodule

// File: tb/tb_multiplier_array_seq_reconstruct_8.sv
// Directed self-checking bench for multiplier_array_seq_reconstruct_8.
// Expected latency follows MULT_EARLY_EXIT_EN.
module tb_multiplier_array_seq_reconstruct_8;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  q;
  logic [7:0]  d;
  logic [7:0]  r;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] n;
  logic        busy;

  int pass_cnt;
  int check_cnt;
  int fail_cnt;
  int n_accepts;

  multiplier_array_seq_reconstruct_8 #(
    .W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q         (q),
    .d         (d),
    .r         (r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .n         (n),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count accepting edges as seen on the interface
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n_accepts <= 0;
    else if (in_valid && in_ready) n_accepts <= n_accepts + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [7:0] qq);
    int l;
`ifdef MULT_EARLY_EXIT_EN
    l = 1;
    for (int i = 0; i < 8; i++) if (qq[i]) l = i + 1;
`else
    l = 8;
`endif
    return l;
  endfunction

  // Present one transaction, measure latency, optionally stall the output
  task automatic do_txn(input string tag, input logic [7:0] tq, input logic [7:0] td,
                        input logic [7:0] tr, input int hold, input logic [15:0] exp_n);
    int lat;
    int bad;
    @(negedge clk);
    q = tq; d = td; r = tr;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    check({tag, "_in_ready_idle"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    q = 8'($urandom); d = 8'($urandom); r = 8'($urandom);
    lat = 0;
    bad = 0;
    while (!out_valid && lat < 40) begin
      if (busy !== 1'b1 || in_ready !== 1'b0) bad++;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_busy_inready_during"}, bad, 0);
    check({tag, "_latency"}, lat, exp_lat(tq));
    check({tag, "_n"}, n, exp_n);
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || n !== exp_n || busy !== 1'b1) bad++;
    end
    if (hold > 0) check({tag, "_held_stable"}, bad, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_out_valid_pulse_end"}, out_valid, 0);
    check({tag, "_in_ready_after_hs"}, in_ready, 1);
    check({tag, "_busy_after_hs"}, busy, 0);
    check({tag, "_n_kept"}, n, exp_n);
  endtask

  initial begin
    int bad;
    int acc_base;
    int lat;
    logic [7:0] bq [3];
    logic [7:0] bd [3];
    logic [7:0] br [3];
    logic [15:0] bexp;

    pass_cnt = 0; check_cnt = 0; fail_cnt = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    q = '0; d = '0; r = '0;

    // Reset values
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_n_out", n, 0);
    @(negedge clk); rst_n = 1'b1;

    do_txn("t1", 8'h0C, 8'h0F, 8'h03, 0, 16'h00B7);
    do_txn("t2", 8'hFF, 8'hFF, 8'hFF, 0, 16'hFF00);
    do_txn("t3", 8'h00, 8'hAB, 8'h5A, 0, 16'h005A);
    do_txn("t4", 8'h03, 8'h10, 8'h00, 5, 16'h0030);

    // Asynchronous abort in the middle of MUL
    @(negedge clk);
    q = 8'h7F; d = 8'h7F; r = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_n", n, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) bad++;
    end
    check("abort_no_out_valid", bad, 0);
    do_txn("t5", 8'h02, 8'h05, 8'h01, 0, 16'h000B);

    // Back-to-back with in_valid held high; operands scrambled outside IDLE
    for (int k = 0; k < 3; k++) begin
      bq[k] = 8'($urandom_range(0, 255));
      bd[k] = 8'($urandom_range(0, 255));
      br[k] = 8'($urandom_range(0, 255));
    end
    acc_base = n_accepts;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      q = bq[k]; d = bd[k]; r = br[k]; in_valid = 1'b1;
      check("b2b_in_ready", in_ready, 1);
      @(posedge clk); #1;
      q = 8'($urandom); d = 8'($urandom); r = 8'($urandom);
      if (k == 2) in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      bexp = 16'(bq[k]) * 16'(bd[k]) + 16'(br[k]);
      check("b2b_latency", lat, exp_lat(bq[k]));
      check("b2b_n", n, bexp);
      @(posedge clk); #1;
      check("b2b_handshake", out_valid, 0);
    end
    repeat (12) @(posedge clk);
    #1;
    check("b2b_accepts", n_accepts - acc_base, 3);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
